// File: rtl/integral_tile_writer_if.sv
// Pixel-stream input and tile-memory write port of the integral tile writer.
// master = pixel producer / memory sink, slave = the writer itself.
interface integral_tile_writer_if #(
    parameter int ADDR_W = 17
) ();
    logic              pix_valid;
    logic [7:0]        pix_data;
    logic              pix_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/integral_tile_writer.sv
// Streams 8-bit raster pixels into a summed-area image of a W x W tile,
// writing one 32-bit integral value per accepted pixel in row-major order.
module integral_tile_writer #(
    parameter int MAX_W  = 316,
    parameter int ADDR_W = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            size,
    integral_tile_writer_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int XW = $clog2(MAX_W + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     w_q, w_d;
    logic [XW-1:0]     x_q, x_d;
    logic [XW-1:0]     y_q, y_d;
    logic [31:0]       rowacc_q, rowacc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       lb [0:MAX_W-1];
    logic [31:0]       lb_rd_q;

    logic [31:0]       w_calc;
    logic              start_ok;
    logic              start_take;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic              tile_end;
    logic [31:0]       rowsum;
    logic [31:0]       prev;
    logic [31:0]       integ;

    assign w_calc     = 32'd3 * {3'b000, size[31:3]};
    assign start_ok   = (w_calc != 32'd0) && (w_calc <= 32'(MAX_W));
    assign start_take = (state_q == S_IDLE) && start;
    assign accept     = (state_q == S_RUN) && bus.pix_valid;
    assign last_col   = (x_q == w_q - 1'b1);
    assign last_row   = (y_q == w_q - 1'b1);
    assign tile_end   = accept && last_col && last_row;

    assign rowsum = ((x_q == '0) ? 32'd0 : rowacc_q) + {24'd0, bus.pix_data};
    assign prev   = (y_q == '0) ? 32'd0 : lb_rd_q;
    assign integ  = rowsum + prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && start_ok) state_d = S_RUN;
            S_RUN:   if (tile_end)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pix_ready = (state_q == S_RUN);
        busy          = (state_q == S_RUN);
    end

    always_comb begin
        w_d      = w_q;
        x_d      = x_q;
        y_d      = y_q;
        rowacc_d = rowacc_q;
        addr_d   = addr_q;
        if (start_take && start_ok) begin
            w_d      = w_calc[XW-1:0];
            x_d      = '0;
            y_d      = '0;
            rowacc_d = 32'd0;
            addr_d   = '0;
        end else if (accept) begin
            rowacc_d = rowsum;
            addr_d   = addr_q + 1'b1;
            if (last_col) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rowacc_q    <= 32'd0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            w_q      <= w_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rowacc_q <= rowacc_d;
            addr_q   <= addr_d;
            mem_we_q <= accept;
            if (accept) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= integ;
            end
            done_q <= tile_end;
            err_q  <= start_take && !start_ok;
        end
    end

    // Registered line-buffer read prefetches the column the next pixel will use;
    // the bypass covers a write and read of the same column in one cycle.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            lb[x_q] <= integ;
        end
        lb_rd_q <= (accept && (x_d == x_q)) ? integ : lb[x_d];
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_integral_tile_writer.sv
// Directed bench for integral_tile_writer: ramp, saturated, bubbled,
// rejected, reset-mid-tile and start-while-busy tiles.
module tb_integral_tile_writer;
    localparam int ADDR_W = 17;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] size;
    logic        busy;
    logic        done;
    logic        err;

    integral_tile_writer_if #(.ADDR_W(ADDR_W)) bus ();

    integral_tile_writer #(.MAX_W(316), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .size  (size),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pix;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        busy;
        logic        ready;
    } wr_t;

    vec_t ramp[9];
    vec_t twos[9];
    int   gaps[9];
    wr_t  wq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic acc_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Every mem_we must follow an acceptance one cycle earlier, and vice versa.
    always @(negedge clk) begin
        if (bus.mem_we || acc_prev) begin
            n_checks++;
            if (bus.mem_we !== acc_prev) begin
                n_fail++;
                $display("FAIL we_follow: mem_we=%b, expected %b at %0t", bus.mem_we, acc_prev, $time);
            end
        end
        if (bus.mem_we === 1'b1) begin
            wq.push_back('{addr: 32'(bus.mem_addr), data: bus.mem_wdata,
                           done: done, busy: busy, ready: bus.pix_ready});
        end
        acc_prev <= bus.pix_valid && bus.pix_ready && !reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [31:0] sz);
        start = 1'b1;
        size  = sz;
        tick(1);
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: bubbles from gaps[], 2: start pulses mid-tile
    task automatic send_vecs(input vec_t v[9], input int mode);
        for (int i = 0; i < 9; i++) begin
            if (mode == 1) begin
                bus.pix_valid = 1'b0;
                tick(gaps[i]);
            end
            if (mode == 2 && (i == 3 || i == 6)) begin
                start = 1'b1;
                size  = 32'd16;
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = v[i].pix;
            tick(1);
            start = 1'b0;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input vec_t v[9]);
        int ndone;
        ndone = 0;
        check({tag, "_count"}, 32'(wq.size()), 32'd9);
        for (int i = 0; i < 9 && i < wq.size(); i++) begin
            check($sformatf("%s_addr[%0d]", tag, i), wq[i].addr, v[i].addr);
            check($sformatf("%s_data[%0d]", tag, i), wq[i].data, v[i].data);
            check($sformatf("%s_done[%0d]", tag, i), 32'(wq[i].done), 32'(v[i].done));
            check($sformatf("%s_busy[%0d]", tag, i), 32'(wq[i].busy), 32'(!v[i].done));
            if (wq[i].done) ndone++;
        end
        check({tag, "_ready_at_done"}, 32'(wq[wq.size()-1].ready), 32'd0);
        check({tag, "_done_pulses"}, 32'(ndone), 32'd1);
        wq.delete();
    endtask

    initial begin
        logic [31:0] ramp_data [9] = '{1, 3, 6, 5, 12, 21, 12, 27, 45};
        logic [31:0] twos_data [9] = '{2, 4, 6, 4, 8, 12, 6, 12, 18};
        int          gap_tab   [9] = '{0, 2, 1, 0, 3, 1, 0, 2, 1};
        int          ndone;
        for (int i = 0; i < 9; i++) begin
            ramp[i] = '{pix: 8'(i + 1), addr: 32'(i), data: ramp_data[i], done: (i == 8)};
            twos[i] = '{pix: 8'd2,      addr: 32'(i), data: twos_data[i], done: (i == 8)};
            gaps[i] = gap_tab[i];
        end

        reset = 1'b1;
        start = 1'b0;
        size  = 32'd0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'd0;
        tick(2);
        reset = 1'b0;
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_err",       32'(err),           32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);

        // 3x3 ramp
        start_tile(32'd8);
        check("start_busy",  32'(busy),          32'd1);
        check("start_ready", 32'(bus.pix_ready), 32'd1);
        send_vecs(ramp, 0);
        tick(3);
        check_writes("ramp", ramp);

        // saturated 6x6
        start_tile(32'd16);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'd255;
        tick(36);
        bus.pix_valid = 1'b0;
        tick(3);
        check("sat_count", 32'(wq.size()), 32'd36);
        if (wq.size() == 36) begin
            check("sat_addr35", wq[35].addr, 32'd35);
            check("sat_data35", wq[35].data, 32'd9180);
            check("sat_data5",  wq[5].data,  32'd1530);
            check("sat_data30", wq[30].data, 32'd1530);
            check("sat_done35", 32'(wq[35].done), 32'd1);
        end
        ndone = 0;
        foreach (wq[i]) if (wq[i].done) ndone++;
        check("sat_done_pulses", 32'(ndone), 32'd1);
        wq.delete();

        // ramp with bubbles
        start_tile(32'd8);
        send_vecs(ramp, 1);
        tick(3);
        check_writes("bubble", ramp);

        // rejected sizes
        start_tile(32'd7);
        check("rej7_err",  32'(err),  32'd1);
        check("rej7_busy", 32'(busy), 32'd0);
        tick(1);
        check("rej7_err_pulse", 32'(err), 32'd0);
        tick(3);
        check("rej7_writes", 32'(wq.size()), 32'd0);
        start_tile(32'd1000);
        check("rej1000_err",  32'(err),  32'd1);
        check("rej1000_busy", 32'(busy), 32'd0);
        tick(1);
        check("rej1000_err_pulse", 32'(err), 32'd0);
        tick(3);
        check("rej1000_writes", 32'(wq.size()), 32'd0);
        wq.delete();

        // reset after 4 ramp pixels, then a tile of all-2 pixels
        start_tile(32'd8);
        for (int i = 0; i < 4; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = ramp[i].pix;
            tick(1);
        end
        bus.pix_valid = 1'b0;
        tick(1);
        check("midrst_pre_writes", 32'(wq.size()), 32'd4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("midrst_busy",  32'(busy),       32'd0);
        check("midrst_we",    32'(bus.mem_we), 32'd0);
        tick(2);
        check("midrst_post_writes", 32'(wq.size()), 32'd4);
        wq.delete();
        start_tile(32'd8);
        send_vecs(twos, 0);
        tick(3);
        check_writes("twos", twos);

        // start pulses while busy are ignored
        start_tile(32'd8);
        send_vecs(ramp, 2);
        tick(3);
        check_writes("busystart", ramp);
        check("busystart_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/integral_tile_writer.md
# integral_tile_writer

Builds the summed-area (integral) image of one detection-core tile from a raster stream of 8-bit grayscale pixels. It writes each 32-bit integral value into the tile image memory that a detection core later reads, with addresses in row-major order at stride `3*(size/8)`. It is the producer end of the core's tile-image interface and replaces the offline preparation of the per-core image file.

## Interface
Parameters:
- `MAX_W`, default 316: largest supported tile width in pixels. This is also the line-buffer depth. 316² fits the 100000-word tile memory.
- `ADDR_W`, default 17: width of the memory address port.

Ports:
- `clk`  in  1: the only clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high. It clears all state and outputs on the next rising edge.
- `start`  in  1: single-cycle request to begin a tile. Sampled only in IDLE.
- `size`  in  32: image size. It is sampled when `start` is accepted. Tile width is `W = 3*(size/8)`, with integer division.
- `pix_valid`  in  1: a pixel is presented.
- `pix_data`  in  8: unsigned pixel value.
- `pix_ready`  out  1: the block accepts a pixel this cycle.
- `mem_we`  out  1: write strobe to the tile memory.
- `mem_addr`  out  ADDR_W: word address, 0 to W*W-1.
- `mem_wdata`  out  32: integral value.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse that accompanies the final write.
- `err`  out  1: one-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE and RUN.
- **IDLE to RUN:** on `start`, latch `W`. If `1 <= W <= MAX_W`, enter RUN and clear `x`, `y`, the row accumulator and the address counter.
- **Rejected start:** if `W == 0` or `W > MAX_W`, pulse `err` on the next cycle and stay in IDLE. No writes occur.
- **Start while busy:** `start` in RUN is ignored.
- **Handshake:** in RUN, `pix_ready = 1`. A pixel is accepted on a cycle where `pix_valid && pix_ready`. In IDLE, `pix_ready = 0`.
- **Per accepted pixel at column `x`, row `y`:**
  - `rowsum = (x==0 ? 0 : rowacc) + pix_data`.
  - `prev = (y==0 ? 0 : lb[x])`.
  - `I = rowsum + prev`.
  - Write `lb[x] <= I` and `rowacc <= rowsum`.
  - Issue a write of `I` to address `y*W + x`. The address comes from an incrementing counter, not a multiplier.
- **Arithmetic:** unsigned, 32-bit. The maximum value is 255·316² = 25,463,280, so no overflow is possible. The line buffer is `MAX_W` × 32 bits with a read-before-write at the same index.
- **Line-buffer contents:** stale entries from an earlier tile or from before a reset are never used, because row 0 forces `prev = 0`.
- **Column/row advance:** `x` wraps to 0 at `W-1`, and `y` then increments.
- **Tile end:** accepting pixel (`x = W-1`, `y = W-1`) ends the tile. The block returns to IDLE and `done` pulses.
- **Reset mid-tile:** the block returns to IDLE with no further writes. A partially written tile is abandoned, and the next `start` rebuilds from address 0.

## Timing
- **Reset values:** `pix_ready`, `mem_we`, `busy`, `done` and `err` are 0. `mem_addr` and `mem_wdata` are 0.
- **Start:** `start` accepted at cycle t gives `busy = 1` and `pix_ready = 1` from t+1.
- **Write latency:** one cycle. A pixel accepted at t gives `mem_we = 1` at t+1, with `mem_addr` and `mem_wdata` valid that cycle. Otherwise `mem_we = 0`, and `addr`/`data` hold their last values.
- **Throughput:** one pixel per cycle. Gaps in `pix_valid` produce equal gaps in `mem_we`.
- **Tile end:** last pixel accepted at t gives `done = 1` and the last write at t+1. At t+1, `busy = 0` and `pix_ready = 0`. A new `start` is accepted from t+1.
- **Rejection:** a rejected `start` at t gives `err = 1` at t+1.
- **Reset priority:** `reset` overrides `start` and pixel acceptance in the same cycle.

## Test plan
- **3×3 ramp:** `size = 8` (W = 3), pixels 1..9 back-to-back → writes to addresses 0..8 of 1, 3, 6, 5, 12, 21, 12, 27, 45. `done` is coincident with address 8, and `pix_ready` drops the same cycle.
- **Saturated tile:** `size = 16` (W = 6), all pixels 255 → address 35 receives 9180, address 5 receives 1530, address 30 receives 1530. Exactly 36 writes occur.
- **Bubbles:** ramp test with `pix_valid` toggled in a pseudo-random pattern → identical address/data sequence, and `mem_we` is never high without a prior acceptance.
- **Invalid sizes:** `size = 7` and `size = 1000` (W = 375) → `err` pulses one cycle later, and there is no `busy` and no `mem_we`.
- **Reset mid-tile:** reset after 4 pixels of the W = 3 ramp, then a fresh `start` with pixels all 2 → writes 2, 4, 6, 4, 8, 12, 6, 12, 18, with no stale line-buffer influence.
- **Start while busy:** `start` pulses in RUN → ignored. Address and row counters continue, and a single `done` is produced.
